// File: rtl/uart_hex_tx.sv
// Byte-to-ASCII-hex UART transmitter: buffers bytes in a small FIFO and sends
// each one as two uppercase hex characters followed by CR LF on an 8N1 line.
module uart_hex_tx #(
    parameter int unsigned CLKS_PER_BIT = 10417,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       serial_out,
    output logic       busy,
    output logic       full,
    output logic       overflow
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, bit_end;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [1:0]    chr_idx;
    logic [7:0]    shreg, byte_reg;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n <= 4'd9) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    function automatic logic [7:0] char_at(input logic [1:0] idx, input logic [7:0] b);
        case (idx)
            2'd0:    return hex_ascii(b[7:4]);
            2'd1:    return hex_ascii(b[3:0]);
            2'd2:    return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign busy    = (count != '0) || (state != IDLE);
    // A strobe while full is dropped even if LOAD frees a slot on the same edge.
    assign push    = in_valid && !full;
    assign pop     = (state == LOAD);
    assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (in_valid && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            serial_out <= 1'b1;
            cnt        <= '0;
            bit_idx    <= '0;
            chr_idx    <= '0;
            shreg      <= '0;
            byte_reg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (count != '0) state <= LOAD;
                end
                LOAD: begin
                    byte_reg   <= mem[rd_ptr];
                    shreg      <= hex_ascii(mem[rd_ptr][7:4]);
                    chr_idx    <= '0;
                    cnt        <= '0;
                    serial_out <= 1'b0;
                    state      <= START;
                end
                START: begin
                    if (bit_end) begin
                        cnt        <= '0;
                        serial_out <= shreg[0];
                        shreg      <= shreg >> 1;
                        bit_idx    <= '0;
                        state      <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            serial_out <= 1'b1;
                            state      <= STOP;
                        end else begin
                            serial_out <= shreg[0];
                            shreg      <= shreg >> 1;
                            bit_idx    <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (chr_idx == 2'd3) begin
                            state <= IDLE;
                        end else begin
                            chr_idx    <= chr_idx + 1'b1;
                            shreg      <= char_at(chr_idx + 2'd1, byte_reg);
                            serial_out <= 1'b0;
                            state      <= START;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_hex_tx.sv
// Directed bench for uart_hex_tx: a line monitor decodes serial_out and the
// main thread compares characters, timing and status flags to fixed values.
module tb_uart_hex_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       serial_out, busy, full, overflow;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int framing = 0;
    int low_cycles = 0;
    int full_cycles = 0;

    logic [7:0] rx_q[$];
    int         rx_t[$];
    logic [7:0] mon_b;
    int         mon_t;
    logic [7:0] exp_bytes[8];
    int         n_exp;

    uart_hex_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .serial_out(serial_out), .busy(busy), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (serial_out === 1'b0) low_cycles <= low_cycles + 1;
        if (full === 1'b1) full_cycles <= full_cycles + 1;
    end

    // Line decoder: samples each bit in its middle; rx_t holds the start-bit edge index.
    initial begin
        forever begin
            @(negedge serial_out);
            @(negedge clk);
            mon_t = cyc;
            @(negedge clk);
            if (serial_out !== 1'b0) continue;
            for (int k = 0; k < 8; k++) begin
                repeat (CPB) @(negedge clk);
                mon_b[k] = serial_out;
            end
            repeat (CPB) @(negedge clk);
            if (serial_out !== 1'b1) framing++;
            rx_q.push_back(mon_b);
            rx_t.push_back(mon_t);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] b, output int e);
        in_data  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        e = cyc;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) tick();
    endtask

    task automatic wait_idle(input int bound, output int t);
        int n = 0;
        while (busy !== 1'b0 && n < bound) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
        t = cyc;
        repeat (4) tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        rx_q.delete();
        rx_t.delete();
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h41 + 8'(n) - 8'd10;
    endfunction

    function automatic logic [7:0] exp_char(input logic [7:0] b, input int k);
        case (k)
            0:       return hexc(b[7:4]);
            1:       return hexc(b[3:0]);
            2:       return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    task automatic check_rx(input string tag);
        check({tag, "_count"}, 32'(rx_q.size()), 32'(4 * n_exp));
        for (int i = 0; i < 4 * n_exp && i < rx_q.size(); i++) begin
            check(tag, 32'(rx_q[i]), 32'(exp_char(exp_bytes[i / 4], i % 4)));
            if (i > 0)
                check({tag, "_gap"}, 32'(rx_t[i] - rx_t[i-1]), (i % 4 == 0) ? 32'd42 : 32'd40);
        end
        check({tag, "_framing"}, 32'(framing), 32'd0);
    endtask

    initial begin
        int e0, e1, t, base;

        // Reset held with strobes toggling
        for (int i = 0; i < 6; i++) begin
            in_valid = i[0];
            in_data  = 8'h5A;
            tick();
            check("rst_serial", 32'(serial_out), 32'd1);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_full", 32'(full), 32'd0);
            check("rst_ovf", 32'(overflow), 32'd0);
        end
        in_valid = 1'b0;
        reset = 1'b1;
        base = low_cycles;
        repeat (60) tick();
        check("post_rst_rx", 32'(rx_q.size()), 32'd0);
        check("post_rst_low", 32'(low_cycles - base), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Single byte 0x3D -> "3D\r\n"
        strobe(8'h3D, e0);
        check("single_busy_rise", 32'(busy), 32'd1);
        wait_idle(400, t);
        n_exp = 1;
        exp_bytes[0] = 8'h3D;
        check_rx("single");
        if (rx_t.size() > 0) begin
            check("single_start", 32'(rx_t[0] - e0), 32'd2);
            check("single_busy_fall", 32'(t - rx_t[0]), 32'd160);
        end
        check("single_line_idle", 32'(serial_out), 32'd1);

        // Hex boundaries 0x00, 0xFF on consecutive cycles
        rx_q.delete();
        rx_t.delete();
        base = full_cycles;
        strobe(8'h00, e0);
        strobe(8'hFF, e1);
        wait_idle(800, t);
        n_exp = 2;
        exp_bytes[0] = 8'h00;
        exp_bytes[1] = 8'hFF;
        check_rx("hexb");
        check("hexb_full_never", 32'(full_cycles - base), 32'd0);

        // Overflow: six back-to-back strobes 0x10..0x15
        rx_q.delete();
        rx_t.delete();
        e0 = 0;
        for (int i = 0; i < 6; i++) begin
            strobe(8'h10 + 8'(i), e1);
            if (i == 0) e0 = e1;
            if (i == 3) check("ovf_full_4th", 32'(full), 32'd0);
            if (i == 4) begin
                check("ovf_full_5th", 32'(full), 32'd1);
                check("ovf_flag_5th", 32'(overflow), 32'd0);
            end
            if (i == 5) begin
                check("ovf_flag_6th", 32'(overflow), 32'd1);
                check("ovf_full_6th", 32'(full), 32'd1);
            end
        end
        wait_idle(1200, t);
        n_exp = 5;
        for (int i = 0; i < 5; i++) exp_bytes[i] = 8'h10 + 8'(i);
        check_rx("ovf");
        if (rx_t.size() > 0) check("ovf_pop_edge", 32'(rx_t[0] - e0), 32'd2);
        check("ovf_sticky", 32'(overflow), 32'd1);
        do_reset();
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Reset during data bits of character 1 of 0xA5, 0x77 queued
        strobe(8'hA5, e0);
        strobe(8'h77, e1);
        wait_until(e0 + 52);
        check("mid_pre_low", 32'(serial_out), 32'd0);
        reset = 1'b0;
        #1;
        check("mid_async_serial", 32'(serial_out), 32'd1);
        check("mid_async_busy", 32'(busy), 32'd0);
        check("mid_async_full", 32'(full), 32'd0);
        tick();
        reset = 1'b1;
        base = low_cycles;
        repeat (60) tick();
        rx_q.delete();
        rx_t.delete();
        repeat (300) tick();
        check("mid_no_tx", 32'(rx_q.size()), 32'd0);
        check("mid_line_high", 32'(low_cycles - base), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);

        // Push on the LOAD pop edge with 3 bytes held: accepted
        strobe(8'h01, e0);
        repeat (10) tick();
        for (int i = 2; i <= 4; i++) strobe(8'(i), e1);
        check("col3_pre_full", 32'(full), 32'd0);
        wait_until(e0 + 163);
        strobe(8'h05, e1);
        check("col3_full", 32'(full), 32'd0);
        check("col3_ovf", 32'(overflow), 32'd0);
        strobe(8'h06, e1);
        check("col3_count4", 32'(full), 32'd1);
        wait_idle(1400, t);
        n_exp = 6;
        for (int i = 0; i < 6; i++) exp_bytes[i] = 8'(i + 1);
        check_rx("col3");
        check("col3_ovf_end", 32'(overflow), 32'd0);

        // Same with 4 bytes held: rejected
        do_reset();
        strobe(8'h01, e0);
        repeat (10) tick();
        for (int i = 2; i <= 5; i++) strobe(8'(i), e1);
        check("col4_pre_full", 32'(full), 32'd1);
        wait_until(e0 + 163);
        strobe(8'h06, e1);
        check("col4_ovf", 32'(overflow), 32'd1);
        check("col4_full", 32'(full), 32'd0);
        wait_idle(1400, t);
        n_exp = 5;
        for (int i = 0; i < 5; i++) exp_bytes[i] = 8'(i + 1);
        check_rx("col4");
        check("col4_ovf_end", 32'(overflow), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
